// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: opens one update window per vertical blank and hands
// it to requesters one at a time over a Grant/Done handshake, rotating priority.
module frame_update_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 1023
) (
  input  logic               i_pixel_clock,
  input  logic               i_resetn,
  input  logic [9:0]         i_xpixel,
  input  logic [9:0]         i_ypixel,
  input  logic               i_enable,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_done,
  input  logic               i_clear_err,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_frame_tick,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout_err,
  output logic [15:0]        o_frame_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_vbl;
  logic               r_vbl_prev;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               r_tick;
  logic               w_tick_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic               r_tmo_err;
  logic               w_tmo_err_nxt;
  logic [15:0]        r_frame_cnt;
  logic [15:0]        w_frame_cnt_nxt;
  logic [TW-1:0]      r_tmo_cnt;
  logic [TW-1:0]      w_tmo_cnt_nxt;
  logic               w_ovr_set;
  logic               w_tmo_set;

  // First pending bit at or after ptr, wrapping; returned one-hot (zero if none).
  function automatic logic [NUM_REQ-1:0] pick_from(input logic [NUM_REQ-1:0] pend,
                                                   input logic [PW-1:0]      ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   low;
    dbl = {pend, pend} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    low = rot & (~rot + {{(NUM_REQ-1){1'b0}}, 1'b1});
    dbl = {low, low} << ptr;
    return dbl[2*NUM_REQ-1:NUM_REQ];
  endfunction

  logic               w_vbl;
  logic               w_vbl_start;
  logic               w_open;
  logic               w_deadline;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_done_hit;
  logic               w_tmo_hit;
  logic [PW-1:0]      w_ptr_inc;

  assign w_vbl       = (i_ypixel >= 10'(V_ACTIVE));
  assign w_vbl_start = r_vbl & ~r_vbl_prev & (i_xpixel < 10'd800);
  assign w_open      = (r_state == S_IDLE) & w_vbl_start & i_enable;
  assign w_deadline  = (r_state != S_IDLE) & ~r_vbl;
  assign w_pick      = pick_from(r_pending, r_ptr);
  assign w_done_hit  = |(i_done & r_grant);
  assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_ptr_inc   = (r_ptr == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : (r_ptr + PW'(1));

  // State and output registers. Blank history resets high so a line already
  // inside blanking at reset release is not mistaken for a fresh vblank start.
  always_ff @(posedge i_pixel_clock) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_vbl       <= 1'b1;
      r_vbl_prev  <= 1'b1;
      r_pending   <= {NUM_REQ{1'b0}};
      r_ptr       <= {PW{1'b0}};
      r_grant     <= {NUM_REQ{1'b0}};
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_tmo_cnt   <= {TW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_vbl       <= w_vbl;
      r_vbl_prev  <= r_vbl;
      r_pending   <= w_pending_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_tick      <= w_tick_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
      r_tmo_err   <= w_tmo_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

  // Next-state selection; the blanking deadline outranks Done and timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_open) w_state_nxt = S_SCAN;
        else        w_state_nxt = S_IDLE;
      end
      S_SCAN: begin
        if (w_deadline)   w_state_nxt = S_IDLE;
        else if (|w_pick) w_state_nxt = S_GRANT;
        else              w_state_nxt = S_IDLE;
      end
      S_GRANT: begin
        if (w_deadline)                   w_state_nxt = S_IDLE;
        else if (w_done_hit || w_tmo_hit) w_state_nxt = S_SCAN;
        else                              w_state_nxt = S_GRANT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the grant, window and error registers.
  always_comb begin
    w_pending_nxt   = r_pending;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_tick_nxt      = 1'b0;
    w_busy_nxt      = r_busy;
    w_frame_cnt_nxt = r_frame_cnt;
    w_tmo_cnt_nxt   = {TW{1'b0}};
    w_ovr_set       = 1'b0;
    w_tmo_set       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_open) begin
          w_tick_nxt      = 1'b1;
          w_busy_nxt      = 1'b1;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_pending_nxt   = i_req;
        end else begin
          w_grant_nxt = {NUM_REQ{1'b0}};
        end
      end
      S_SCAN: begin
        if (w_deadline) begin
          w_ovr_set     = |r_pending;
          w_pending_nxt = {NUM_REQ{1'b0}};
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = w_ptr_inc;
        end else if (|w_pick) begin
          w_grant_nxt   = w_pick;
          w_pending_nxt = r_pending & ~w_pick;
        end else begin
          w_busy_nxt = 1'b0;
          w_ptr_nxt  = w_ptr_inc;
        end
      end
      S_GRANT: begin
        if (w_deadline) begin
          w_ovr_set     = 1'b1;
          w_grant_nxt   = {NUM_REQ{1'b0}};
          w_pending_nxt = {NUM_REQ{1'b0}};
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = w_ptr_inc;
        end else if (w_done_hit) begin
          w_grant_nxt = {NUM_REQ{1'b0}};
        end else if (w_tmo_hit) begin
          w_grant_nxt = {NUM_REQ{1'b0}};
          w_tmo_set   = 1'b1;
        end else begin
          w_tmo_cnt_nxt = (r_tmo_cnt == TW'(TIMEOUT)) ? r_tmo_cnt : (r_tmo_cnt + TW'(1));
        end
      end
      default: begin
        w_grant_nxt   = {NUM_REQ{1'b0}};
        w_pending_nxt = {NUM_REQ{1'b0}};
        w_busy_nxt    = 1'b0;
      end
    endcase
    if (w_ovr_set)        w_overrun_nxt = 1'b1;
    else if (i_clear_err) w_overrun_nxt = 1'b0;
    else                  w_overrun_nxt = r_overrun;
    if (w_tmo_set)        w_tmo_err_nxt = 1'b1;
    else if (i_clear_err) w_tmo_err_nxt = 1'b0;
    else                  w_tmo_err_nxt = r_tmo_err;
  end

  assign o_grant       = r_grant;
  assign o_frame_tick  = r_tick;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_tmo_err;
  assign o_frame_count = r_frame_cnt;

endmodule
